// File: rtl/codec_init_seq.sv
// Audio codec register-initialisation sequencer.
// Walks a fixed nine-word table out to the I2C engine with per-word retry.
module codec_init_seq #(
    parameter int MAX_RETRY  = 3,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic        SCLK,
    input  logic        rstn,
    input  logic        start,
    input  logic        i2c_done,
    input  logic [2:0]  i2c_ack,
    output logic        i2c_start,
    output logic [15:0] i2c_word,
    output logic        busy,
    output logic        init_done,
    output logic        init_err,
    output logic [3:0]  reg_index,
    output logic [1:0]  retry_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [2:0]  MAXR   = 3'(MAX_RETRY);
    localparam logic [7:0]  TMO    = 8'(TIMEOUT);
    localparam logic [15:0] GAPM1  = 16'(GAP_CYCLES - 1);
    localparam logic [3:0]  LAST   = 4'd8;

    state_t      state, state_d;
    logic [15:0] word_d;
    logic [3:0]  idx_d;
    logic [1:0]  retry_d;
    logic        done_d, err_d;
    logic [7:0]  tcnt, tcnt_d;
    logic [15:0] gcnt, gcnt_d;
    logic [2:0]  ack, ack_d;
    logic [2:0]  retry_nx;

    function automatic logic [15:0] table_word(input logic [3:0] i);
        logic [15:0] w;
        case (i)
            4'd0:    w = 16'h1E00;
            4'd1:    w = 16'h0C00;
            4'd2:    w = 16'h0812;
            4'd3:    w = 16'h0A00;
            4'd4:    w = 16'h0E23;
            4'd5:    w = 16'h102F;
            4'd6:    w = 16'h0460;
            4'd7:    w = 16'h0660;
            4'd8:    w = 16'h1201;
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    always_ff @(posedge SCLK) begin
        if (!rstn) begin
            state     <= S_IDLE;
            i2c_word  <= 16'h0000;
            reg_index <= 4'd0;
            retry_cnt <= 2'd0;
            init_done <= 1'b0;
            init_err  <= 1'b0;
            tcnt      <= 8'd0;
            gcnt      <= 16'd0;
            ack       <= 3'b000;
        end else begin
            state     <= state_d;
            i2c_word  <= word_d;
            reg_index <= idx_d;
            retry_cnt <= retry_d;
            init_done <= done_d;
            init_err  <= err_d;
            tcnt      <= tcnt_d;
            gcnt      <= gcnt_d;
            ack       <= ack_d;
        end
    end

    always_comb begin
        state_d  = state;
        word_d   = i2c_word;
        idx_d    = reg_index;
        retry_d  = retry_cnt;
        done_d   = init_done;
        err_d    = init_err;
        tcnt_d   = tcnt;
        gcnt_d   = gcnt;
        ack_d    = ack;
        retry_nx = {1'b0, retry_cnt} + 3'd1;
        unique case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    idx_d   = 4'd0;
                    retry_d = 2'd0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                word_d  = table_word(reg_index);
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                tcnt_d  = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // a completion arriving on the timeout cycle still counts
                if (i2c_done) begin
                    ack_d   = i2c_ack;
                    state_d = S_CHECK;
                end else begin
                    tcnt_d = tcnt + 8'd1;
                    if (tcnt_d == TMO) begin
                        ack_d   = 3'b111;
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                gcnt_d = 16'd0;
                if (ack == 3'b000) begin
                    if (reg_index == LAST) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = reg_index + 4'd1;
                        retry_d = 2'd0;
                        state_d = S_GAP;
                    end
                end else begin
                    retry_d = retry_nx[1:0];
                    if (retry_nx == MAXR) begin
                        err_d   = 1'b1;
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gcnt == GAPM1) begin
                    gcnt_d  = 16'd0;
                    state_d = S_LOAD;
                end else begin
                    gcnt_d = gcnt + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign i2c_start = (state == S_ISSUE);
    assign busy      = !(state == S_IDLE || state == S_DONE ||
                         state == S_ERROR);

endmodule

// File: tb/tb_codec_init_seq.sv
// Directed bench for codec_init_seq with a small I2C engine model.
// Engine logs every i2c_start; checks compare logs with hand tables.
module tb_codec_init_seq;

    logic        SCLK = 1'b0;
    logic        rstn;
    logic        start;
    logic        i2c_done;
    logic [2:0]  i2c_ack;
    logic        i2c_start;
    logic [15:0] i2c_word;
    logic        busy;
    logic        init_done;
    logic        init_err;
    logic [3:0]  reg_index;
    logic [1:0]  retry_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] tbl [0:8] = '{16'h1E00, 16'h0C00, 16'h0812, 16'h0A00,
                               16'h0E23, 16'h102F, 16'h0460, 16'h0660,
                               16'h1201};

    logic [15:0] wlog[$];
    int          clog[$];
    logic [1:0]  rlog[$];
    int          att    [0:8];
    int          fail_n [0:8];
    logic [2:0]  fail_ack;
    bit          withhold;
    bit          stray_en;
    int          pend = 0;
    bit          fa   = 0;
    int          k    = 0;
    int          c0;

    codec_init_seq dut (
        .SCLK      (SCLK),
        .rstn      (rstn),
        .start     (start),
        .i2c_done  (i2c_done),
        .i2c_ack   (i2c_ack),
        .i2c_start (i2c_start),
        .i2c_word  (i2c_word),
        .busy      (busy),
        .init_done (init_done),
        .init_err  (init_err),
        .reg_index (reg_index),
        .retry_cnt (retry_cnt)
    );

    always #5 SCLK = ~SCLK;

    always @(posedge SCLK) cyc <= cyc + 1;

    // Engine model: answers 3 cycles after a start unless withheld.
    always @(negedge SCLK) begin
        if (i2c_start === 1'b1) begin
            wlog.push_back(i2c_word);
            clog.push_back(cyc);
            rlog.push_back(retry_cnt);
            att[reg_index] = att[reg_index] + 1;
            fa       = (att[reg_index] <= fail_n[reg_index]);
            pend     = withhold ? 0 : 3;
            i2c_done = 1'b0;
        end else if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                i2c_done = 1'b1;
                i2c_ack  = fa ? fail_ack : 3'b000;
            end else begin
                i2c_done = 1'b0;
            end
        end else begin
            i2c_done = stray_en && (k % 3 == 0);
            i2c_ack  = stray_en ? 3'b111 : 3'b000;
            k = k + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        wlog.delete();
        clog.delete();
        rlog.delete();
        for (int i = 0; i < 9; i++) begin
            att[i]    = 0;
            fail_n[i] = 0;
        end
        withhold = 1'b0;
        stray_en = 1'b0;
        fail_ack = 3'b000;
    endtask

    task automatic kick();
        @(negedge SCLK);
        start = 1'b1;
        c0    = cyc;
        @(negedge SCLK);
        start = 1'b0;
    endtask

    task automatic run_to_idle(input string tag, input int bound);
        int n = 0;
        do begin
            @(negedge SCLK);
            n++;
        end while (busy && n < bound);
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_start"}, i2c_start, 0);
        chk({tag, "_word"},  i2c_word, 16'h0000);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  init_done, 0);
        chk({tag, "_err"},   init_err, 0);
        chk({tag, "_idx"},   reg_index, 0);
        chk({tag, "_retry"}, retry_cnt, 0);
    endtask

    task automatic chk_full_run(input string tag);
        chk({tag, "_n"}, wlog.size(), 9);
        for (int i = 0; i < 9 && i < wlog.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), wlog[i], tbl[i]);
        chk({tag, "_done"}, init_done, 1);
        chk({tag, "_err"},  init_err, 0);
        chk({tag, "_idx"},  reg_index, 8);
    endtask

    initial begin
        int n;
        int ord [0:9] = '{0, 1, 2, 3, 4, 4, 5, 6, 7, 8};
        rstn     = 1'b0;
        start    = 1'b0;
        i2c_done = 1'b0;
        i2c_ack  = 3'b000;
        clear_logs();
        repeat (2) @(negedge SCLK);
        chk_reset_vals("rst");
        rstn = 1'b1;

        // clean run, all words acknowledged
        clear_logs();
        kick();
        chk("t1_busy", busy, 1);
        run_to_idle("t1", 400);
        chk_full_run("t1");
        if (clog.size() >= 2) begin
            chk("t1_lat", clog[0] - c0, 2);
            chk("t1_gap", clog[1] - clog[0], 22);
        end else begin
            chk("t1_clog", clog.size(), 2);
        end

        // single NACK on index 4
        clear_logs();
        fail_n[4] = 1;
        fail_ack  = 3'b010;
        kick();
        run_to_idle("t2", 500);
        chk("t2_n", wlog.size(), 10);
        for (int i = 0; i < 10 && i < wlog.size(); i++)
            chk($sformatf("t2_w%0d", i), wlog[i], tbl[ord[i]]);
        if (rlog.size() >= 6) begin
            chk("t2_r4a", rlog[4], 0);
            chk("t2_r4b", rlog[5], 1);
        end
        chk("t2_done", init_done, 1);

        // index 2 never acknowledged
        clear_logs();
        fail_n[2] = 99;
        fail_ack  = 3'b100;
        kick();
        run_to_idle("t3", 500);
        chk("t3_n", wlog.size(), 5);
        for (int i = 2; i < 5 && i < wlog.size(); i++)
            chk($sformatf("t3_w%0d", i), wlog[i], 16'h0812);
        chk("t3_err",  init_err, 1);
        chk("t3_done", init_done, 0);
        chk("t3_idx",  reg_index, 2);

        // engine silent: every attempt times out
        clear_logs();
        withhold = 1'b1;
        kick();
        chk("t4_errclr", init_err, 0);
        run_to_idle("t4", 1200);
        chk("t4_n", wlog.size(), 3);
        if (clog.size() >= 3) begin
            chk("t4_sp1", clog[1] - clog[0], 274);
            chk("t4_sp2", clog[2] - clog[1], 274);
            chk("t4_r2",  rlog[2], 2);
        end
        chk("t4_err", init_err, 1);
        chk("t4_idx", reg_index, 0);

        // reset pulse while waiting on index 5
        clear_logs();
        kick();
        n = 0;
        while (clog.size() < 6 && n < 400) begin
            @(negedge SCLK);
            #1;
            n++;
        end
        chk("t5_reach", clog.size(), 6);
        @(negedge SCLK);
        chk("t5_busy", busy, 1);
        chk("t5_idx5", reg_index, 5);
        rstn = 1'b0;
        @(negedge SCLK);
        chk_reset_vals("t5rst");
        rstn = 1'b1;
        repeat (6) @(negedge SCLK);
        clear_logs();
        kick();
        run_to_idle("t5", 400);
        chk_full_run("t5");

        // stray completions and start held mid-sequence
        clear_logs();
        stray_en = 1'b1;
        kick();
        n = 0;
        while (clog.size() < 3 && n < 200) begin
            @(negedge SCLK);
            #1;
            n++;
        end
        start = 1'b1;
        repeat (5) @(negedge SCLK);
        start = 1'b0;
        run_to_idle("t6", 400);
        chk_full_run("t6");
        repeat (30) @(negedge SCLK);
        chk("t6_noextra", wlog.size(), 9);
        chk("t6_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/codec_init_seq.md
# codec_init_seq

Register-initialisation sequencer for the audio codec on the I2C control bus. It walks a fixed table of nine 16-bit codec words (7-bit register address in [15:9], 9-bit data in [8:0]) and hands each word to the I2C protocol engine with a one-cycle start pulse. After each start it waits for the engine's completion pulse, checks the three ACK bits, and retries failed words. It reports completion or failure to the audio playback logic, which holds ROM reads and the DAC clocks until `init_done` is high.

## Interface
Parameters:
- MAX_RETRY, 3: attempts per word before the sequence aborts (≥1).
- GAP_CYCLES, 16: idle SCLK cycles between a completed transfer and the next start (≥1).
- TIMEOUT, 255: SCLK cycles to wait for `i2c_done` before the attempt counts as failed (≤255).

Ports:
- SCLK, input, 1: block clock, rising-edge.
- rstn, input, 1: reset, synchronous, active-low.
- start, input, 1: level; sampled in IDLE, DONE and ERROR to begin a full sequence.
- i2c_done, input, 1: one-cycle pulse from the I2C engine marking the end of a transfer.
- i2c_ack, input, 3: ACK bits of the last transfer; 3'b000 means all three bytes were acknowledged.
- i2c_start, output, 1: one-cycle request to the I2C engine.
- i2c_word, output, 16: word for the engine; stable from LOAD until the next LOAD.
- busy, output, 1: high in every state except IDLE, DONE and ERROR.
- init_done, output, 1: sticky success flag.
- init_err, output, 1: sticky abort flag.
- reg_index, output, 4: index of the current word, 0..8.
- retry_cnt, output, 2: failed attempts on the current word.

## Operation
- Table, in index order: 0:1E00 (reset), 1:0C00 (power down ctrl), 2:0812 (analog path), 3:0A00 (digital path), 4:0E23 (interface format), 5:102F (sampling), 6:0460 (L headphone), 7:0660 (R headphone), 8:1201 (activate).
- States: IDLE, LOAD, ISSUE, WAIT, CHECK, GAP, DONE, ERROR.
- IDLE/DONE/ERROR with start=1: reg_index←0, retry_cnt←0, clear init_done and init_err, go to LOAD.
- LOAD: i2c_word←table[reg_index]; go to ISSUE.
- ISSUE: i2c_start=1 for this cycle only (Moore output); clear the timeout counter; go to WAIT.
- WAIT:
  - i2c_done=1: latch i2c_ack, go to CHECK.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT, go to CHECK with the latched ACK forced to 3'b111.
  - If i2c_done and the timeout occur in the same cycle, i2c_done wins.
- CHECK:
  - ACK==000 and reg_index==8: go to DONE and set init_done.
  - ACK==000 and reg_index<8: reg_index+1, retry_cnt←0, go to GAP.
  - Otherwise: retry_cnt+1. If the new value equals MAX_RETRY, go to ERROR and set init_err. Else go to GAP with reg_index unchanged.
- GAP: count GAP_CYCLES cycles, then go to LOAD.
- i2c_done outside WAIT is ignored.
- start while busy is ignored.
- reg_index never exceeds 8.
- retry_cnt saturates by construction because ERROR is entered before the count can wrap.

## Timing
- Reset values: i2c_start=0, i2c_word=16'h0000, busy=0, init_done=0, init_err=0, reg_index=0, retry_cnt=0, state=IDLE, counters=0.
- Reset mid-operation: all outputs take their reset values at the next rising edge. i2c_start is never asserted in that cycle.
- start sampled high at edge k: LOAD after k, i2c_start high in the cycle after edge k+1.
- i2c_done sampled at edge d: CHECK after d, next state after d+1.
- Successive i2c_start pulses on one word: at least GAP_CYCLES+4 cycles apart (ISSUE, WAIT≥1, CHECK, GAP, LOAD).
- Timeout: CHECK is entered TIMEOUT cycles after ISSUE when i2c_done never arrives.
- All outputs are registered or decoded from the state register only, with no combinational path from the inputs.

## Test plan
- Engine always returns i2c_done 3 cycles after each i2c_start, ACK=000 -> nine i2c_start pulses carrying words 1E00..1201 in table order, then init_done=1, busy=0, reg_index=8.
- ACK=3'b010 on the first attempt of index 4, 000 afterwards -> 0E23 issued twice with retry_cnt=1 between attempts, then the sequence completes with init_done=1.
- ACK≠000 on every attempt of index 2 -> exactly 3 pulses of 0812, then init_err=1, init_done=0, busy=0, reg_index=2.
- i2c_done withheld at index 0 -> CHECK entered 255 cycles after each ISSUE; after 3 attempts init_err=1.
- rstn low for 1 cycle during WAIT at index 5 -> every output at its reset value on the next edge; a new start replays from 1E00.
- Stray i2c_done pulses in GAP, plus start asserted mid-sequence -> no extra i2c_start, sequence ordering unaffected.
